hist_percentile_scan: RTL and testbench

- Downstream consumer of the ping-pong histogram statistics block.
- After each frame, it sweeps the completed (back) histogram RAM through that block's read port and accumulates the cumulative distribution.
- It reports the low and high percentile bins plus the peak bin and its count.
- Auto-contrast and auto-exposure control logic uses these results, and they stay stable for a whole frame.

---
 rtl/hist_percentile_scan_if.sv | 23 ++
 rtl/hist_percentile_scan.sv | 176 +++++++++++++++++
 tb/tb_hist_percentile_scan.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hist_percentile_scan_if.sv
// rtl/hist_percentile_scan_if.sv - histogram RAM read port between scanner and histogram block
interface hist_percentile_scan_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 24
);
    logic                 hist_rd_en;
    logic [ADDR_BITS-1:0] hist_rd_addr;
    logic [DATA_BITS-1:0] hist_rd_data;

    // Scanner side: issues enable/address, receives data one cycle later
    modport master (
        output hist_rd_en,
        output hist_rd_addr,
        input  hist_rd_data
    );

    // Histogram RAM side
    modport slave (
        input  hist_rd_en,
        input  hist_rd_addr,
        output hist_rd_data
    );
endinterface

// File: rtl/hist_percentile_scan.sv
// rtl/hist_percentile_scan.sv - sweeps a completed histogram, reports percentile and peak bins
module hist_percentile_scan #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 24,
    parameter int CNT_BITS  = 32,
    parameter int PCT_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_BITS-1:0]   total_pix,
    input  logic [PCT_BITS-1:0]   low_pct,
    input  logic [PCT_BITS-1:0]   high_pct,
    hist_percentile_scan_if.master rd,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_BITS-1:0]  low_bin,
    output logic [ADDR_BITS-1:0]  high_bin,
    output logic [ADDR_BITS-1:0]  max_bin,
    output logic [DATA_BITS-1:0]  max_count
);
    localparam int SUM_BITS  = CNT_BITS + 1;
    localparam int PROD_BITS = CNT_BITS + PCT_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_BIN = '1;

    typedef enum logic [2:0] {IDLE, INIT, READ, DRAIN, DONE_S} state_t;

    state_t               state;
    logic [CNT_BITS-1:0]  total_r;
    logic [PCT_BITS-1:0]  low_pct_r;
    logic [PCT_BITS-1:0]  high_pct_r;
    logic [CNT_BITS-1:0]  low_thr;
    logic [CNT_BITS-1:0]  high_thr;
    logic [CNT_BITS-1:0]  cdf;
    logic                 found_lo;
    logic                 found_hi;
    logic [ADDR_BITS-1:0] lo_r;
    logic [ADDR_BITS-1:0] hi_r;
    logic [DATA_BITS-1:0] max_count_r;
    logic [ADDR_BITS-1:0] max_bin_r;
    // vld marks a cycle where hist_rd_data belongs to bin bin_k
    logic                 vld;
    logic [ADDR_BITS-1:0] bin_k;

    logic [PROD_BITS-1:0] low_prod;
    logic [PROD_BITS-1:0] high_prod;
    logic [SUM_BITS-1:0]  cdf_sum;
    logic [CNT_BITS-1:0]  cdf_sat;
    logic [CNT_BITS-1:0]  cdf_n;
    logic                 found_lo_n;
    logic                 found_hi_n;
    logic [ADDR_BITS-1:0] lo_n;
    logic [ADDR_BITS-1:0] hi_n;
    logic [DATA_BITS-1:0] max_count_n;
    logic [ADDR_BITS-1:0] max_bin_n;

    // Threshold products are full width so the shift never loses high bits
    always_comb begin
        low_prod  = {{PCT_BITS{1'b0}}, total_r} * {{CNT_BITS{1'b0}}, low_pct_r};
        high_prod = {{PCT_BITS{1'b0}}, total_r} * {{CNT_BITS{1'b0}}, high_pct_r};
    end

    // Next-state of the CDF/peak accumulators for the datum arriving this cycle
    always_comb begin
        cdf_sum     = {1'b0, cdf} + {{(SUM_BITS-DATA_BITS){1'b0}}, rd.hist_rd_data};
        cdf_sat     = cdf_sum[CNT_BITS] ? '1 : cdf_sum[CNT_BITS-1:0];
        cdf_n       = cdf;
        found_lo_n  = found_lo;
        found_hi_n  = found_hi;
        lo_n        = lo_r;
        hi_n        = hi_r;
        max_count_n = max_count_r;
        max_bin_n   = max_bin_r;
        if (vld) begin
            cdf_n = cdf_sat;
            if (!found_lo && (cdf_sat > low_thr)) begin
                found_lo_n = 1'b1;
                lo_n       = bin_k;
            end
            if (!found_hi && (cdf_sat > high_thr)) begin
                found_hi_n = 1'b1;
                hi_n       = bin_k;
            end
            // strict compare keeps the lowest bin on ties
            if (rd.hist_rd_data > max_count_r) begin
                max_count_n = rd.hist_rd_data;
                max_bin_n   = bin_k;
            end
        end
    end

    // Sweep FSM with registered bus/status/result outputs and accumulators
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            total_r         <= '0;
            low_pct_r       <= '0;
            high_pct_r      <= '0;
            low_thr         <= '0;
            high_thr        <= '0;
            cdf             <= '0;
            found_lo        <= 1'b0;
            found_hi        <= 1'b0;
            lo_r            <= '0;
            hi_r            <= '0;
            max_count_r     <= '0;
            max_bin_r       <= '0;
            vld             <= 1'b0;
            bin_k           <= '0;
            rd.hist_rd_en   <= 1'b0;
            rd.hist_rd_addr <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            low_bin         <= '0;
            high_bin        <= '0;
            max_bin         <= '0;
            max_count       <= '0;
        end else begin
            vld         <= rd.hist_rd_en;
            bin_k       <= rd.hist_rd_addr;
            cdf         <= cdf_n;
            found_lo    <= found_lo_n;
            found_hi    <= found_hi_n;
            lo_r        <= lo_n;
            hi_r        <= hi_n;
            max_count_r <= max_count_n;
            max_bin_r   <= max_bin_n;
            case (state)
                IDLE: begin
                    if (start) begin
                        total_r    <= total_pix;
                        low_pct_r  <= low_pct;
                        high_pct_r <= high_pct;
                        busy       <= 1'b1;
                        state      <= INIT;
                    end
                end
                INIT: begin
                    low_thr         <= low_prod[PROD_BITS-1:PCT_BITS];
                    high_thr        <= high_prod[PROD_BITS-1:PCT_BITS];
                    cdf             <= '0;
                    found_lo        <= 1'b0;
                    found_hi        <= 1'b0;
                    max_count_r     <= '0;
                    max_bin_r       <= '0;
                    rd.hist_rd_en   <= 1'b1;
                    rd.hist_rd_addr <= '0;
                    state           <= READ;
                end
                READ: begin
                    if (rd.hist_rd_addr == LAST_BIN) begin
                        rd.hist_rd_en <= 1'b0;
                        state         <= DRAIN;
                    end else begin
                        rd.hist_rd_addr <= rd.hist_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // last bin is folded in this cycle, so publish from the next-state values
                    low_bin   <= found_lo_n ? lo_n : LAST_BIN;
                    high_bin  <= found_hi_n ? hi_n : LAST_BIN;
                    max_bin   <= max_bin_n;
                    max_count <= max_count_n;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE_S;
                end
                DONE_S: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hist_percentile_scan.sv
// tb/tb_hist_percentile_scan.sv - self-checking bench for hist_percentile_scan
module tb_hist_percentile_scan;
    localparam int AB = 8;
    localparam int DB = 24;
    localparam int CB = 32;
    localparam int PB = 8;
    localparam int N  = 256;
    localparam int LAT = N + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CB-1:0] total_pix = '0;
    logic [PB-1:0] low_pct = '0;
    logic [PB-1:0] high_pct = '0;
    logic          busy;
    logic          done;
    logic [AB-1:0] low_bin;
    logic [AB-1:0] high_bin;
    logic [AB-1:0] max_bin;
    logic [DB-1:0] max_count;

    always #5 clk = ~clk;

    hist_percentile_scan_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    hist_percentile_scan #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(CB), .PCT_BITS(PB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .total_pix(total_pix),
        .low_pct(low_pct), .high_pct(high_pct), .rd(bus),
        .busy(busy), .done(done), .low_bin(low_bin), .high_bin(high_bin),
        .max_bin(max_bin), .max_count(max_count)
    );

    logic [DB-1:0] mem [N];
    logic [DB-1:0] rnd [N];

    // Histogram RAM model: registered read, data one cycle after enable
    always @(posedge clk) begin
        if (bus.hist_rd_en) bus.hist_rd_data <= mem[bus.hist_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AB-1:0] lo;
        logic [AB-1:0] hi;
        logic [AB-1:0] mb;
        logic [DB-1:0] mc;
        int            t0;
    } exp_t;

    typedef struct {
        int            pat;
        logic [CB-1:0] tot;
        logic [PB-1:0] lo;
        logic [PB-1:0] hi;
        exp_t          e;
    } vec_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint want);
        checks++;
        if (act == want) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, want);
    endtask

    // Scoreboard / protocol monitor
    int  en_cnt = 0;
    int  exp_addr = 0;
    bit  addr_err = 0;
    int  done_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            en_cnt = 0; exp_addr = 0; addr_err = 0;
        end else begin
            if (bus.hist_rd_en) begin
                if (int'(bus.hist_rd_addr) != exp_addr) addr_err = 1;
                exp_addr++;
                en_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("low_bin", low_bin, e.lo);
                    check("high_bin", high_bin, e.hi);
                    check("max_bin", max_bin, e.mb);
                    check("max_count", max_count, e.mc);
                    check("latency", cyc - e.t0, LAT);
                    check("rd_en_cycles", en_cnt, N);
                    check("addr_order_err", addr_err, 0);
                end
                en_cnt = 0; exp_addr = 0; addr_err = 0;
            end
        end
    end

    function automatic exp_t model(input logic [CB-1:0] tot, input logic [PB-1:0] lo, input logic [PB-1:0] hi);
        exp_t   r;
        longint lthr, hthr, c;
        bit     fl, fh;
        lthr = (longint'(tot) * longint'(lo)) >>> PB;
        hthr = (longint'(tot) * longint'(hi)) >>> PB;
        c = 0; fl = 0; fh = 0;
        r.lo = '1; r.hi = '1; r.mb = '0; r.mc = '0; r.t0 = 0;
        for (int k = 0; k < N; k++) begin
            c = c + longint'(mem[k]);
            if (c > 64'hFFFF_FFFF) c = 64'hFFFF_FFFF;
            if (!fl && c > lthr) begin fl = 1; r.lo = AB'(k); end
            if (!fh && c > hthr) begin fh = 1; r.hi = AB'(k); end
            if (mem[k] > r.mc) begin r.mc = mem[k]; r.mb = AB'(k); end
        end
        return r;
    endfunction

    task automatic load(input int pat);
        for (int k = 0; k < N; k++) begin
            case (pat)
                0: mem[k] = 1;
                1: mem[k] = (k == 100) ? DB'(1000) : '0;
                2: mem[k] = '0;
                3: mem[k] = '1;
                default: mem[k] = rnd[k];
            endcase
        end
    endtask

    task automatic pulse_start(input logic [CB-1:0] tot, input logic [PB-1:0] lo,
                               input logic [PB-1:0] hi, input exp_t e, input bit push);
        @(negedge clk);
        start = 1'b1; total_pix = tot; low_pct = lo; high_pct = hi;
        e.t0 = cyc;
        if (push) q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 2 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 0, 1);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, bus.hist_rd_en, 0);
        check({tag, "_rd_addr"}, bus.hist_rd_addr, 0);
        check({tag, "_low_bin"}, low_bin, 0);
        check({tag, "_high_bin"}, high_bin, 0);
        check({tag, "_max_bin"}, max_bin, 0);
        check({tag, "_max_count"}, max_count, 0);
    endtask

    vec_t vecs[7];

    initial begin
        exp_t e;
        int   d0, n;
        longint sum;

        sum = 0;
        for (int k = 0; k < N; k++) begin
            rnd[k] = DB'($urandom_range(0, 1000));
            sum += longint'(rnd[k]);
        end

        vecs[0] = '{0, 32'd256, 8'd13, 8'd243, '{8'd13, 8'd243, 8'd0, 24'd1, 0}};
        vecs[1] = '{0, 32'd256, 8'd200, 8'd10, '{8'd200, 8'd10, 8'd0, 24'd1, 0}};
        vecs[2] = '{1, 32'd1000, 8'd0, 8'd255, '{8'd100, 8'd100, 8'd100, 24'd1000, 0}};
        vecs[3] = '{2, 32'd0, 8'd77, 8'd200, '{8'd255, 8'd255, 8'd0, 24'd0, 0}};
        vecs[4] = '{3, 32'hFFFF_FFFF, 8'd128, 8'd255, '{8'd128, 8'd255, 8'd0, 24'hFF_FFFF, 0}};
        load(4);
        vecs[5] = '{4, CB'(sum), 8'd64, 8'd192, model(CB'(sum), 8'd64, 8'd192)};
        vecs[6] = '{0, 32'd256, 8'd0, 8'd255, '{8'd0, 8'd255, 8'd0, 24'd1, 0}};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].pat);
            pulse_start(vecs[i].tot, vecs[i].lo, vecs[i].hi, vecs[i].e, 1'b1);
            check("busy_at_start_plus1", busy, 1);
            wait_idle();
        end

        // Second start mid-sweep ignored, pct change mid-sweep ignored, results held
        load(0);
        d0 = done_cnt;
        e = '{8'd13, 8'd243, 8'd0, 24'd1, 0};
        pulse_start(32'd256, 8'd13, 8'd243, e, 1'b1);
        repeat (47) @(negedge clk);
        pulse_start(32'd256, 8'd250, 8'd1, e, 1'b0);
        check("held_low_bin", low_bin, 0);
        check("held_high_bin", high_bin, 255);
        wait_idle();
        repeat (5) @(negedge clk);
        check("single_done", done_cnt - d0, 1);

        // Start in the cycle right after done is accepted
        load(1);
        e = '{8'd100, 8'd100, 8'd100, 24'd1000, 0};
        pulse_start(32'd1000, 8'd0, 8'd255, e, 1'b1);
        n = 0;
        while (!done && n < 2 * LAT) begin @(negedge clk); n++; end
        check("done_seen", done, 1);
        e = '{8'd0, 8'd255, 8'd0, 24'd1, 0};
        load(0);
        pulse_start(32'd256, 8'd0, 8'd255, e, 1'b1);
        check("busy_after_back2back", busy, 1);
        wait_idle();

        // Reset mid-READ aborts the sweep
        load(0);
        d0 = done_cnt;
        pulse_start(32'd256, 8'd13, 8'd243, e, 1'b1);
        repeat (100) @(negedge clk);
        check("rd_en_mid_read", bus.hist_rd_en, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 20) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 0);

        // Fresh sweep after reset
        load(1);
        e = '{8'd100, 8'd100, 8'd100, 24'd1000, 0};
        pulse_start(32'd1000, 8'd0, 8'd255, e, 1'b1);
        wait_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
